// File: rtl/scan_select_sequencer.sv
// Slot sequencer producing the 3-bit select code for a downstream 3-to-8 decoder.
// Walks the set bits of a live mask with ACTIVE/BLANK timing, one-shot or continuous.
module scan_select_sequencer #(
  parameter int TICK_DIV     = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [7:0] mask,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       slot_tick,
  output logic       frame_done,
  output logic       busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_code;
  logic [2:0] r_pend;

  logic       w_has_next;
  logic [2:0] w_next;
  logic [2:0] w_low;
  logic [2:0] w_target;
  logic       w_decide;
  logic       w_go_idle;

  always_comb begin
    w_has_next = 1'b0;
    w_next     = 3'd0;
    w_low      = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (3'(i) > r_code)) begin
        w_has_next = 1'b1;
        w_next     = 3'(i);
      end
      if (mask[i]) w_low = 3'(i);
    end
  end

  // Wrap to the lowest set bit when the frame ends and cont asks for another.
  assign w_target  = w_has_next ? w_next : w_low;
  assign w_decide  = (r_state == S_ACTIVE) && (r_cnt == TICK_LAST);
  assign w_go_idle = ~(|mask) || (~w_has_next && ~cont);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_code  <= 3'd0;
      r_pend  <= 3'd0;
    end else if (stop) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (|mask)) begin
            r_state <= S_ACTIVE;
            r_code  <= w_low;
            r_cnt   <= 8'd0;
          end
        end
        S_ACTIVE: begin
          if (r_cnt != TICK_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (w_go_idle) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= 8'd0;
            if (BLANK_CYCLES == 0) begin
              r_state <= S_ACTIVE;
              r_code  <= w_target;
            end else begin
              r_state <= S_BLANK;
              r_pend  <= w_target;
            end
          end
        end
        S_BLANK: begin
          if (r_cnt != BLANK_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_state <= S_ACTIVE;
            r_code  <= r_pend;
            r_cnt   <= 8'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign code       = r_code;
  assign code_valid = (r_state == S_ACTIVE);
  assign slot_tick  = (r_state == S_ACTIVE) && (r_cnt == 8'd0);
  assign busy       = (r_state != S_IDLE);
  // Judged on the live mask in the decision cycle; an abort suppresses it.
  assign frame_done = w_decide && (|mask) && ~w_has_next && ~stop;

endmodule

// File: doc/scan_select_sequencer.md
# scan_select_sequencer

Timed slot sequencer that generates the 3-bit select code feeding the team's 3-to-8 decoder. It drives the decoder input during each active slot and blanks it between slots. Slots are chosen by an 8-bit mask, and the block runs one-shot or continuous frames. It sits directly upstream of the decoder in display/keypad scan paths.

## Interface
- TICK_DIV, 4: clock cycles each slot is driven (ACTIVE); legal range 1..255
- BLANK_CYCLES, 1: blank cycles between consecutive slots; 0 = back-to-back slots; legal 0..255
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  frame request; honoured only in IDLE with mask != 0
- stop  input  1  abort; forces IDLE on next edge (priority over everything except reset)
- cont  input  1  sampled at frame end: 1 = start next frame, 0 = return to IDLE
- mask  input  8  slot enable, bit i enables code i; sampled live at each slot decision
- code  output  3  select code to decoder input
- code_valid  output  1  high only while a slot is ACTIVE (decoder output meaningful)
- slot_tick  output  1  one-cycle pulse in first ACTIVE cycle of every slot
- frame_done  output  1  one-cycle pulse in last ACTIVE cycle of the frame's final slot
- busy  output  1  high in ACTIVE and BLANK

## Operation
- States: IDLE, ACTIVE, BLANK; cycle counter cnt, 8 bits.
- IDLE: code holds last value (000 after reset), code_valid=0, busy=0. start=1 and mask!=0 -> ACTIVE, code = lowest set mask bit, cnt=0. start with mask=0 ignored.
- ACTIVE: code stable, code_valid=1; cnt counts 0..TICK_DIV-1. On cnt=TICK_DIV-1 the next slot is chosen:
  - next = lowest set mask bit with index > code.
  - If one exists: go BLANK (BLANK_CYCLES>0) or ACTIVE with code=next (BLANK_CYCLES=0).
  - If none exists, this is the last slot: frame_done=1 this cycle and cont is sampled.
    - cont=1: wrap to lowest set bit, via BLANK if BLANK_CYCLES>0.
    - cont=0: go IDLE.
  - If mask=0 at the decision: go IDLE; frame_done is not asserted.
- BLANK: code holds previous slot value, code_valid=0, busy=1; after BLANK_CYCLES cycles -> ACTIVE with the pending code.
  - The pending code is latched at the ACTIVE decision; mask changes during BLANK do not alter it.
- code changes only on the edge entering ACTIVE.
- stop=1 in any state: IDLE next edge, code_valid=0, no frame_done, code holds.
- start while busy is ignored and is not queued.
- Reset (asynchronous, any time): state=IDLE, code=000, cnt=0, all outputs 0 immediately, without a clock edge.

## Timing
- Start accepted at edge k: at cycle k+1 code_valid=1, slot_tick=1, code=first slot.
- Per slot: TICK_DIV ACTIVE cycles, then BLANK_CYCLES blank cycles, except after the final slot when cont=0.
- One-shot frame with N set mask bits: busy high for N*TICK_DIV + (N-1)*BLANK_CYCLES cycles.
- Continuous period per frame: N*(TICK_DIV+BLANK_CYCLES) cycles.
- TICK_DIV=1: every ACTIVE cycle is both slot_tick and decision cycle; for a single-slot frame, slot_tick and frame_done coincide.
- Simultaneous stop and frame_done condition: stop wins, frame_done=0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> code=000, code_valid=0, busy=0, slot_tick=0, frame_done=0. Assert rst_n=0 mid-ACTIVE -> outputs clear with no clock edge.
- Defaults, mask=8'hFF, start pulse, cont=0:
  - codes 0..7 each valid for 4 cycles with 1 blank cycle between.
  - frame_done in the 4th cycle of code 7; busy high for exactly 39 cycles.
- Sparse mask, mask=8'b1000_0101, cont=1 -> sequence 0,2,7,0,2,7…; frame_done once per 15-cycle frame.
- BLANK_CYCLES=0, TICK_DIV=1, mask=8'h01, cont=0 -> one ACTIVE cycle with code=0; slot_tick and frame_done coincide; then IDLE.
- Abort:
  - stop in 2nd ACTIVE cycle of code 3 -> IDLE next edge, code stays 011, no frame_done.
  - A start during busy is ignored.
  - start with mask=0 is ignored.
- Live mask: clear mask to 0 during ACTIVE of code 1 -> IDLE after that slot, frame_done=0.
